// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register map and FSM state encoding.
package irq_pkg;

    localparam int unsigned IRQC_ID_W = 5;

    localparam logic [1:0] IRQC_ENABLE  = 2'd0;
    localparam logic [1:0] IRQC_PENDING = 2'd1;
    localparam logic [1:0] IRQC_ACTIVE  = 2'd2;
    localparam logic [1:0] IRQC_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of i_vec and whether any bit is set.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = IRQC_ID_W
) (
    input  logic [N_SRC-1:0] i_vec,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_id
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        o_valid = 1'b0;
        o_id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_valid = 1'b1;
                o_id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped fixed-priority interrupt controller with a single outstanding interrupt.
// Define IRQC_EDGE_EN for rising-edge source capture; level capture otherwise.
module irq_controller
    import irq_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = IRQC_ID_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [1:0]       address,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             irq_ack,
    output logic             cpu_irq,
    output logic [ID_W-1:0]  irq_id
);

    logic [N_SRC-1:0] r_enable;
    logic [N_SRC-1:0] r_pending;
    irq_state_e       r_state;
    logic             r_cpu_irq;
    logic [ID_W-1:0]  r_irq_id;

    logic [N_SRC-1:0] w_set;
    logic [N_SRC-1:0] w_w1c;
    logic [N_SRC-1:0] w_ack_clr;
    logic [N_SRC-1:0] w_avail;
    logic [N_SRC-1:0] w_id_mask;
    logic             w_id_pending;
    logic             w_id_enabled;
    logic             w_enc_valid;
    logic [ID_W-1:0]  w_enc_id;
    logic             w_en_wr;
    logic             w_eoi;
    logic             w_unused;

    assign w_unused = ^write_data;

    assign w_en_wr   = MemWrite && (address == IRQC_ENABLE);
    assign w_w1c     = (MemWrite && (address == IRQC_PENDING)) ? write_data[N_SRC-1:0] : '0;
    assign w_eoi     = MemWrite && (address == IRQC_ACTIVE);
    assign w_avail   = r_pending & r_enable;
    assign w_id_mask = N_SRC'(1) << r_irq_id;

    assign w_id_pending = |(r_pending & w_id_mask);
    assign w_id_enabled = |(r_enable & w_id_mask);

`ifdef IRQC_EDGE_EN
    logic [N_SRC-1:0] r_src_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_q <= '0;
        end else begin
            r_src_q <= irq_src;
        end
    end

    assign w_set     = irq_src & ~r_src_q;
    assign w_ack_clr = ((r_state == S_REQ) && irq_ack) ? w_id_mask : '0;
`else
    // Level mode: the handler clears PENDING itself, so ack leaves it alone.
    assign w_set     = irq_src;
    assign w_ack_clr = '0;
`endif

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .i_vec   (w_avail),
        .o_valid (w_enc_valid),
        .o_id    (w_enc_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable  <= '0;
            r_pending <= '0;
            r_state   <= S_IDLE;
            r_cpu_irq <= 1'b0;
            r_irq_id  <= '0;
        end else begin
            // A new capture wins over a same-cycle clear of that bit.
            r_pending <= (r_pending & ~w_w1c & ~w_ack_clr) | w_set;
            if (w_en_wr) begin
                r_enable <= write_data[N_SRC-1:0];
            end

            case (r_state)
                S_IDLE: begin
                    if (w_enc_valid) begin
                        r_state   <= S_REQ;
                        r_cpu_irq <= 1'b1;
                        r_irq_id  <= w_enc_id;
                    end
                end
                S_REQ: begin
                    if (irq_ack) begin
                        r_state   <= S_SERVICE;
                        r_cpu_irq <= 1'b0;
                    end else if (!w_id_pending || !w_id_enabled) begin
                        r_state   <= S_IDLE;
                        r_cpu_irq <= 1'b0;
                    end
                end
                S_SERVICE: begin
                    if (w_eoi) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cpu_irq <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        read_data = '0;
        if (MemRead) begin
            case (address)
                IRQC_ENABLE:  read_data = 32'(r_enable);
                IRQC_PENDING: read_data = 32'(r_pending);
                IRQC_ACTIVE:  read_data = 32'(r_irq_id);
                IRQC_STATUS:  read_data = {29'b0, (r_state == S_SERVICE), r_cpu_irq, |w_avail};
                default:      read_data = '0;
            endcase
        end
    end

    assign cpu_irq = r_cpu_irq;
    assign irq_id  = r_irq_id;

endmodule
